uart_rx_unit: RTL and testbench
===============================

Name: uart_rx_unit

Overview:
Serial receive end of the team's UART link. It takes the single-wire line driven by the transmitter and recovers 8-bit data frames. Frame format is start bit, 8 data bits LSB first, optional odd/even parity, one stop bit. It oversamples the line 16x from the 50 MHz system clock and reports data, activity, completion and a 3-bit error code. The baud_rate and parity_type encodings match the transmitter, so a Duplex loopback pairs the two directly.

Parameters:
CLOCK_HZ, 50000000, system clock frequency; used only to derive the divisor constants below.
OVERSAMPLE, 16, sample ticks per bit; the fixed value is 16.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
rx  input  1  serial line; idles high; asynchronous to clock.
parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
baud_rate  input  2  00 2400, 01 4800, 10 9600, 11 19200.
data_out  output  8  last received byte.
rx_active_flag  output  1  high while a frame is being received.
rx_done_flag  output  1  one-cycle pulse when a frame completes.
error_flag  output  3  [0] parity error, [1] start-bit glitch, [2] stop/framing error.

Behaviour:
- Reset (reset_n low, asynchronous): data_out=8'h00, rx_active_flag=0, rx_done_flag=0, error_flag=3'b000, FSM=IDLE, all counters 0, both synchronizer flops = 1.
- rx passes through a 2-flop synchronizer. All detection uses the synchronized value rx_s.
- Tick generator: free counter reloads at divisor-1 and emits a 1-cycle tick.
  - Divisor = round(CLOCK_HZ/(16*baud)): 1302 / 651 / 326 / 163 for codes 00/01/10/11.
  - The counter restarts from 0 on start detection.
- baud_rate and parity_type are latched at start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Bit value = majority of rx_s sampled at ticks 7, 8, 9 of each 16-tick bit, decided at tick 9.
  - The bit period ends at tick 15.
- IDLE -> START on a 1->0 transition of rx_s.
  - At entry: error_flag cleared to 000, rx_active_flag=1.
- START, at tick 9:
  - Majority 0 -> continue; DATA begins at the next bit boundary.
  - Majority 1 -> error_flag[1]=1, rx_active_flag=0, return to IDLE. No rx_done_flag. data_out unchanged.
- DATA: 8 bits shifted in LSB first; a 3-bit counter tracks the bit index. After bit 7, go to PARITY if parity is enabled (01/10), else to STOP.
- PARITY: expected bit = ^data for even; ~^data for odd. A mismatch sets error_flag[0]=1 and the frame still continues.
- STOP, at tick 9:
  - Majority 0 sets error_flag[2]=1.
  - In either case, the same cycle: data_out<=shift register, rx_done_flag=1 for exactly one clock, rx_active_flag=0, FSM=IDLE.
  - The receiver returns to IDLE at mid-stop, so a following start edge is accepted immediately.
- data_out changes only on rx_done_flag and holds its value otherwise, even when errors are flagged. error_flag holds until the next start detection.
- Line held low after a framing error: no new start is recognised until rx_s has returned high and falls again.
- Reset asserted mid-frame aborts immediately. After release the block waits in IDLE for a fresh falling edge.
- Latency: rx_done_flag rises 9.5 bit times (no parity) or 10.5 bit times (parity) after the start edge, plus 2–3 clocks of synchronizer delay.

Test Plan:
1. 9600 baud, odd parity, clean frame 8'hAA, parity bit 1, stop 1 -> rx_done_flag pulses once, 1 clock wide, about 10.5×5216 clocks after the start edge; data_out=8'hAA; error_flag=000; rx_active_flag high throughout the frame.
2. 19200 baud, even parity, 8'hAA with parity bit driven 1 (wrong) -> data_out=8'hAA; error_flag=001; done pulse present.
3. 2400 baud, no parity (11), 8'h3C with stop bit driven 0 -> error_flag=100; data_out=8'h3C; rx stays low afterwards -> no second frame until rx rises and falls.
4. 4800 baud: 2-bit-tick-wide low glitch (about 1300 clocks) on idle rx -> error_flag=010; no rx_done_flag; data_out unchanged; next clean frame 8'h55 is received with error_flag=000.
5. 9600 baud, no parity: back-to-back frames 8'h01 then 8'hFE with no idle gap; baud_rate switched to 11 mid-frame-1 -> both bytes received correctly at 9600; error_flag=000.
6. reset_n pulsed low during DATA bit 4 -> outputs immediately reset to defaults; next full frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_unit.sv
// UART receiver: 2-flop synchronizer, 16x oversampling with 3-sample majority vote,
// 8 data bits LSB first, optional odd/even parity, one stop bit.
module uart_rx_unit #(
  parameter int CLOCK_HZ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       rx_active_flag,
  output logic       rx_done_flag,
  output logic [2:0] error_flag
);

  // Rounded divisors: clocks per oversample tick for each baud code.
  localparam int DIV_2400  = (CLOCK_HZ + (OVERSAMPLE * 2400) / 2)  / (OVERSAMPLE * 2400);
  localparam int DIV_4800  = (CLOCK_HZ + (OVERSAMPLE * 4800) / 2)  / (OVERSAMPLE * 4800);
  localparam int DIV_9600  = (CLOCK_HZ + (OVERSAMPLE * 9600) / 2)  / (OVERSAMPLE * 9600);
  localparam int DIV_19200 = (CLOCK_HZ + (OVERSAMPLE * 19200) / 2) / (OVERSAMPLE * 19200);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_rx_m;
  logic        r_rx_s;
  logic        r_rx_prev;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_tick;
  logic [2:0]  r_bit_idx;
  logic        r_s7;
  logic        r_s8;
  logic [7:0]  r_shift;
  logic [1:0]  r_baud;
  logic [1:0]  r_par;
  logic [7:0]  r_data;
  logic        r_active;
  logic        r_done;
  logic [2:0]  r_err;

  logic [15:0] w_div_m1;
  logic        w_tick;
  logic        w_maj;
  logic        w_par_en;
  logic        w_exp_par;

  always_comb begin
    w_div_m1 = 16'(DIV_2400 - 1);
    case (r_baud)
      2'b00:   w_div_m1 = 16'(DIV_2400 - 1);
      2'b01:   w_div_m1 = 16'(DIV_4800 - 1);
      2'b10:   w_div_m1 = 16'(DIV_9600 - 1);
      default: w_div_m1 = 16'(DIV_19200 - 1);
    endcase
  end

  assign w_tick    = (r_div_cnt == w_div_m1);
  assign w_maj     = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
  assign w_par_en  = (r_par == 2'b01) || (r_par == 2'b10);
  assign w_exp_par = (r_par == 2'b10) ? (^r_shift) : (~^r_shift);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_m    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_m    <= rx;
      r_rx_s    <= r_rx_m;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_shift   <= '0;
      r_baud    <= '0;
      r_par     <= '0;
      r_data    <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        // Holding the counters at zero here restarts bit timing on the start edge.
        r_div_cnt <= '0;
        r_tick    <= '0;
        r_bit_idx <= '0;
        if (r_rx_prev && !r_rx_s) begin
          r_state  <= S_START;
          r_baud   <= baud_rate;
          r_par    <= parity_type;
          r_err    <= '0;
          r_active <= 1'b1;
        end
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_tick    <= r_tick + 4'd1;
        if (r_tick == 4'd7) r_s7 <= r_rx_s;
        if (r_tick == 4'd8) r_s8 <= r_rx_s;
        case (r_state)
          S_START: begin
            if (r_tick == 4'd9 && w_maj) begin
              r_err[1] <= 1'b1;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else if (r_tick == 4'd15) begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (r_tick == 4'd9) r_shift <= {w_maj, r_shift[7:1]};
            if (r_tick == 4'd15) begin
              if (r_bit_idx == 3'd7) r_state <= w_par_en ? S_PARITY : S_STOP;
              else                   r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
          S_PARITY: begin
            if (r_tick == 4'd9 && (w_maj != w_exp_par)) r_err[0] <= 1'b1;
            if (r_tick == 4'd15) r_state <= S_STOP;
          end
          S_STOP: begin
            // Finish at mid-stop so a back-to-back start edge is not missed.
            if (r_tick == 4'd9) begin
              if (!w_maj) r_err[2] <= 1'b1;
              r_data   <= r_shift;
              r_done   <= 1'b1;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end
    end
  end

  assign data_out       = r_data;
  assign rx_active_flag = r_active;
  assign rx_done_flag   = r_done;
  assign error_flag     = r_err;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: a serial-line driver pushes the expected byte/error
// per frame, and a monitor pops and compares on every rx_done_flag pulse.
module tb_uart_rx_unit;

  localparam int CLK_HZ = 1000000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b00;
  logic [7:0] data_out;
  logic       rx_active_flag;
  logic       rx_done_flag;
  logic [2:0] error_flag;

  uart_rx_unit #(.CLOCK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx             (rx),
    .parity_type    (parity_type),
    .baud_rate      (baud_rate),
    .data_out       (data_out),
    .rx_active_flag (rx_active_flag),
    .rx_done_flag   (rx_done_flag),
    .error_flag     (error_flag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [2:0] err;
    int         t0;
    int         lat;
    int         tol;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clocks per oversample tick, from the nominal baud rate of each code.
  function automatic int div_of(input logic [1:0] b);
    int baud;
    baud = 2400 << b;
    return (CLK_HZ + 8 * baud) / (16 * baud);
  endfunction

  task automatic wait_bits(input logic [1:0] b, input int n);
    repeat (n * 16 * div_of(b)) @(negedge clock);
  endtask

  // Must be entered on a falling clock edge; drives one whole frame.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                            input bit bad_par, input bit stop_val, input bit hold_low,
                            input bit scramble);
    int   div;
    bit   par_en;
    bit   pbit;
    int   ones;
    exp_t e;
    div    = div_of(b);
    par_en = (p == 2'b01) || (p == 2'b10);
    baud_rate   = b;
    parity_type = p;
    e.data = d;
    e.err  = {~stop_val, 1'b0, par_en & bad_par};
    e.t0   = cyc;
    e.lat  = ((par_en ? 10 : 9) * 16 + 8) * div + 3;
    e.tol  = 3 * div + 3;
    sb.push_back(e);
    last_data = d;
    rx = 1'b0;
    repeat (16 * div) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (8 * div) @(negedge clock);
      check("active_mid_frame", int'(rx_active_flag), 1);
      if (scramble && i == 3) begin
        baud_rate   = 2'b11;
        parity_type = 2'($urandom_range(3, 0));
      end
      repeat (8 * div) @(negedge clock);
    end
    if (par_en) begin
      ones = $countones(d);
      pbit = (p == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
      if (bad_par) pbit = ~pbit;
      rx = pbit;
      repeat (16 * div) @(negedge clock);
    end
    rx = stop_val;
    repeat (16 * div) @(negedge clock);
    if (!stop_val && !hold_low) begin
      rx = 1'b1;
      repeat (16 * div) @(negedge clock);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    bit   prev_done;
    exp_t e;
    int   lat;
    int   diff;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && rx_done_flag) begin
        check("done_width", int'(prev_done), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 data_out=%0h (t=%0t)", data_out, $time);
        end else begin
          e = sb.pop_front();
          check("data_out", int'(data_out), int'(e.data));
          check("error_flag", int'(error_flag), int'(e.err));
          check("active_at_done", int'(rx_active_flag), 0);
          lat  = cyc - e.t0;
          diff = (lat > e.lat) ? lat - e.lat : e.lat - lat;
          checks++;
          if (diff > e.tol) begin
            errors++;
            $display("FAIL done_latency actual=%0d required=%0d+-%0d", lat, e.lat, e.tol);
          end
        end
      end
      prev_done = reset_n & rx_done_flag;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] b;
    logic [1:0] p;
    bit         bp;
    bit         sv;
    bit         sc;

    repeat (3) @(negedge clock);
    check("rst_data_out", int'(data_out), 0);
    check("rst_active", int'(rx_active_flag), 0);
    check("rst_done", int'(rx_done_flag), 0);
    check("rst_error", int'(error_flag), 0);
    reset_n = 1'b1;
    wait_bits(2'b10, 1);

    send_frame(8'hAA, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_bits(2'b10, 1);
    send_frame(8'hAA, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_bits(2'b11, 1);

    // Framing error with the line left low: no further frame may start.
    send_frame(8'h3C, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_bits(2'b00, 22);
    check("low_line_active", int'(rx_active_flag), 0);
    check("low_line_pending", sb.size(), 0);
    check("low_line_error", int'(error_flag), 3'b100);
    rx = 1'b1;
    wait_bits(2'b00, 1);

    // Start-bit glitch two ticks wide.
    baud_rate   = 2'b01;
    parity_type = 2'b00;
    rx = 1'b0;
    repeat (2 * div_of(2'b01)) @(negedge clock);
    rx = 1'b1;
    wait_bits(2'b01, 2);
    check("glitch_error", int'(error_flag), 3'b010);
    check("glitch_data_held", int'(data_out), int'(last_data));
    check("glitch_active", int'(rx_active_flag), 0);
    send_frame(8'h55, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back frames; baud_rate disturbed mid-frame must not matter.
    send_frame(8'h01, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFE, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_bits(2'b10, 1);

    // Reset during data bit 4.
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    rx = 1'b0;
    wait_bits(2'b10, 1);
    d = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_bits(2'b10, 1);
    end
    rx = d[4];
    repeat (8 * div_of(2'b10)) @(negedge clock);
    check("pre_reset_active", int'(rx_active_flag), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_data_out", int'(data_out), 0);
    check("mid_rst_active", int'(rx_active_flag), 0);
    check("mid_rst_error", int'(error_flag), 0);
    last_data = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    wait_bits(2'b10, 1);
    check("post_rst_active", int'(rx_active_flag), 0);
    send_frame(8'hC3, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom);
      b  = 2'($urandom_range(3, 1));
      p  = 2'($urandom_range(3, 0));
      bp = ($urandom_range(3, 0) == 0);
      sv = ($urandom_range(4, 0) != 0);
      sc = ($urandom_range(1, 0) == 1);
      send_frame(d, b, p, bp, sv, 1'b0, sc);
    end

    repeat (50) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
